cambia_datos: RTL and testbench



---
 rtl/cambia_datos.sv | 127 ++++++++++++
 tb/tb_cambia_datos.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cambia_datos.sv
// Restoring-divider bring-down core plus a four-step sequencer that iterates it.
// The sequencer produces a 4-bit quotient and a 5-bit remainder.
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_RUN  | one bring-down/compare/subtract step per cycle, k = 0..3
// S_DONE | cociente/residuo valid, done pulses for this cycle
module cambia_datos (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] R_in,
  input  logic [3:0] A,
  input  logic [1:0] indice,
  output logic [4:0] R_out,
  input  logic [3:0] B,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] cociente,
  output logic [4:0] residuo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] a_reg, b_reg;
  logic [4:0] r;
  logic [3:0] q;
  logic [1:0] k;

  logic [4:0] t;
  logic       ge;
  logic [4:0] r_step;
  logic [3:0] q_step;
  logic [1:0] q_sel;

  // Shared by the free-standing core output and the sequencer step.
  function automatic logic [4:0] bring_down(input logic [4:0] rem,
                                            input logic [3:0] dvd,
                                            input logic [1:0] idx);
    logic [1:0] sel;
    sel = 2'd3 - idx;
    return {rem[3:0], dvd[sel]};
  endfunction

  always_comb begin
    R_out = bring_down(R_in, A, indice);
  end

  always_comb begin
    t      = bring_down(r, a_reg, k);
    ge     = (t >= {1'b0, b_reg});
    r_step = ge ? (t - {1'b0, b_reg}) : t;
    q_sel  = 2'd3 - k;
    q_step = q;
    q_step[q_sel] = ge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (k == 2'd3) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Results are loaded on the final step edge so they are valid throughout S_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      r        <= '0;
      q        <= '0;
      k        <= '0;
      cociente <= '0;
      residuo  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            r     <= '0;
            q     <= '0;
            k     <= '0;
          end
        end
        S_RUN: begin
          r <= r_step;
          q <= q_step;
          k <= k + 2'd1;
          if (k == 2'd3) begin
            cociente <= q_step;
            residuo  <= r_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cambia_datos.sv
// Self-checking bench for cambia_datos: core sweeps, directed and random
// divisions against an arithmetic reference, start-while-busy and mid-run reset.
module tb_cambia_datos;

  logic       clk;
  logic       rst_n;
  logic [4:0] R_in;
  logic [3:0] A;
  logic [1:0] indice;
  logic [4:0] R_out;
  logic [3:0] B;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] cociente;
  logic [4:0] residuo;

  int tests = 0;
  int fails = 0;

  cambia_datos dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .R_in     (R_in),
    .A        (A),
    .indice   (indice),
    .R_out    (R_out),
    .B        (B),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cociente (cociente),
    .residuo  (residuo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference core: shift left within 5 bits, bring in the selected dividend bit.
  function automatic int core_model(input int r, input int a, input int idx);
    return ((r * 2) % 32) + ((a >> (3 - idx)) % 2);
  endfunction

  task automatic core_check(input int r, input int a, input int idx, input string tag);
    R_in = r[4:0]; A = a[3:0]; indice = idx[1:0];
    #1;
    check(tag, int'(R_out), core_model(r, a, idx));
  endtask

  // Runs one division; optionally pulses start with other operands mid-run.
  task automatic divide(input int a, input int b, input bit inject, input string tag);
    int exp_q, exp_r, lat;
    if (b == 0) begin
      exp_q = 15; exp_r = a;
    end else begin
      exp_q = a / b; exp_r = a % b;
    end
    @(negedge clk);
    A = a[3:0]; B = b[3:0]; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 4'($urandom); B = 4'($urandom);
    check({tag, " busy_after_start"}, int'(busy), 1);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      if (inject && c == 2) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " cociente"}, int'(cociente), exp_q);
    check({tag, " residuo"}, int'(residuo), exp_r);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int ra, rb;
    rst_n = 1'b0; R_in = '0; A = '0; B = '0; indice = '0; start = 1'b0;
    #12;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset cociente", int'(cociente), 0);
    check("reset residuo", int'(residuo), 0);
    @(negedge clk);
    rst_n = 1'b1;

    core_check(0, 4'b1011, 0, "core single");
    check("core single literal", int'(R_out), 5'b00001);
    for (int i = 0; i < 4; i++) core_check(5'b00101, 4'b1100, i, "core index sweep");
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 4; i++) core_check(r, 4'b0110, i, "core full sweep");
    core_check(3, 4'b0110, 1, "core r3 i1");
    check("core r3 i1 literal", int'(R_out), 5'b00111);
    for (int n = 0; n < 20; n++)
      core_check(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), "core random");

    divide(4'b1101, 4'b0011, 1'b0, "div 13/3");
    divide(4'b1111, 4'b0001, 1'b0, "div 15/1");
    divide(4'b1010, 4'b0000, 1'b1, "div by zero");
    repeat (3) @(posedge clk);
    #1;
    check("hold cociente", int'(cociente), 15);
    check("hold residuo", int'(residuo), 10);

    // Back-to-back: next start right after done.
    divide(4'b0111, 4'b0010, 1'b0, "b2b first");
    divide(4'b1000, 4'b0011, 1'b0, "b2b second");

    for (int n = 0; n < 16; n++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      divide(ra, rb, 1'b0, "div random");
    end

    // Reset mid-run.
    @(negedge clk);
    A = 4'b1110; B = 4'b0011; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset cociente", int'(cociente), 0);
    check("midreset residuo", int'(residuo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    divide(4'b1001, 4'b0010, 1'b0, "after reset 9/2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
